// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the iterative datapath blocks.
package arith_pkg;

  // Control states of the chunked subtractor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Width of a counter able to hold 0..steps-1; never narrower than 1 bit.
  function automatic int clog2_steps(input int steps);
    int w;
    w = 1;
    while ((1 << w) < steps) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/iterative_subtractor.sv
// Multi-cycle ripple-borrow subtractor: diff = a - b - bin, K bits per cycle
// over N/K cycles, with valid/ready handshakes on operands and result.
module iterative_subtractor
  import arith_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int STEPS = (K >= 1) ? (N / K) : 1;
  localparam int IDX_W = clog2_steps(STEPS);

  if (N < 1 || K < 1 || K > N || ((K >= 1) ? (N % K) : 1) != 0) begin : g_param_check
    $error("iterative_subtractor: need N >= 1, 1 <= K <= N and N %% K == 0");
  end

  sub_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic             bin_q;
  logic [N-1:0]     diff_q;
  logic             brw_q;
  logic             bout_q;
  logic             ovf_q;

  logic [K-1:0]     a_chunk;
  logic [K-1:0]     b_chunk;
  logic [K-1:0]     d_chunk;
  logic [K:0]       chain;
  logic             last;

  // Select the operand chunk addressed by the chunk index.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int j = 0; j < STEPS; j++) begin
      if (idx == IDX_W'(j)) begin
        a_chunk = a_q[j*K +: K];
        b_chunk = b_q[j*K +: K];
      end
    end
  end

  // Chunk 0 borrows from the operation's bin; later chunks from the previous chunk.
  assign chain[0] = (idx == '0) ? bin_q : brw_q;
  assign last     = (idx == IDX_W'(STEPS - 1));

  for (genvar i = 0; i < K; i++) begin : g_chain
    full_subtractor u_fs (
      .a    (a_chunk[i]),
      .b    (b_chunk[i]),
      .bin  (chain[i]),
      .d    (d_chunk[i]),
      .bout (chain[i+1])
    );
  end

  // Operand capture on acceptance; these are pure data and carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_q   <= a;
      b_q   <= b;
      bin_q <= bin;
    end
  end

  // Control FSM, chunk counter, borrow chain register and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      brw_q  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            idx   <= '0;
            brw_q <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          for (int j = 0; j < STEPS; j++) begin
            if (idx == IDX_W'(j)) diff_q[j*K +: K] <= d_chunk;
          end
          brw_q <= chain[K];
          if (last) begin
            // The last chunk holds the sign bit, so the flags resolve here.
            bout_q <= chain[K];
            ovf_q  <= (a_q[N-1] ^ b_q[N-1]) & (d_chunk[K-1] ^ a_q[N-1]);
            idx    <= '0;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_iterative_subtractor.sv
// Self-checking bench: four instances (N=8, K=1,2,4,8) against an arithmetic
// reference model, plus directed handshake, backpressure and reset scenarios.
module tb_iterative_subtractor;

  logic       clk;
  logic       rst;
  logic       in_valid_s  [4];
  logic       in_ready_s  [4];
  logic [7:0] a_s         [4];
  logic [7:0] b_s         [4];
  logic       bin_s       [4];
  logic       out_valid_s [4];
  logic       out_ready_s [4];
  logic [7:0] diff_s      [4];
  logic       bout_s      [4];
  logic       ovf_s       [4];

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance u uses K = 1 << u, so its latency is 8 >> u cycles.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    iterative_subtractor #(.N(8), .K(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_s[g]),
      .a         (a_s[g]),
      .b         (b_s[g]),
      .bin       (bin_s[g]),
      .out_valid (out_valid_s[g]),
      .out_ready (out_ready_s[g]),
      .diff      (diff_s[g]),
      .bout      (bout_s[g]),
      .ovf       (ovf_s[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction, unsigned and signed interpretations.
  task automatic model(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       output logic [7:0] d, output logic bo, output logic ov);
    int ur;
    int sr;
    ur = int'(av) - int'(bv) - int'(bi);
    sr = int'($signed(av)) - int'($signed(bv)) - int'(bi);
    d  = 8'(ur);
    bo = (ur < 0);
    ov = (sr < -128) || (sr > 127);
  endtask

  // One transaction on instance u; holds out_ready low for 'hold' cycles after
  // out_valid while offering fresh operands that must be ignored.
  task automatic do_op(input int u, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi, input int hold,
                       input logic [7:0] ed, input logic eb, input logic eo);
    int lat;
    out_ready_s[u] = (hold == 0);
    a_s[u]         = av;
    b_s[u]         = bv;
    bin_s[u]       = bi;
    in_valid_s[u]  = 1'b1;
    check("in_ready_idle", in_ready_s[u], 1);
    @(posedge clk); #1;
    in_valid_s[u] = 1'b0;
    lat = 0;
    while (!out_valid_s[u] && lat <= 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 8 >> u);
    check("diff", diff_s[u], ed);
    check("bout", bout_s[u], eb);
    check("ovf", ovf_s[u], eo);
    for (int h = 0; h < hold; h++) begin
      in_valid_s[u] = ~h[0];
      a_s[u]        = 8'($urandom);
      b_s[u]        = 8'($urandom);
      bin_s[u]      = 1'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid_s[u], 1);
      check("hold_diff", diff_s[u], ed);
      check("hold_bout", bout_s[u], eb);
      check("hold_ovf", ovf_s[u], eo);
      check("hold_in_ready", in_ready_s[u], 0);
    end
    in_valid_s[u]  = 1'b0;
    out_ready_s[u] = 1'b1;
    @(posedge clk); #1;
    check("post_valid", out_valid_s[u], 0);
    check("post_in_ready", in_ready_s[u], 1);
  endtask

  // Bound on total run time in case the design wedges outside a bounded loop.
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] av, bv, ed;
    logic       bi, eb, eo;
    int         hold;

    rst = 1'b1;
    for (int u = 0; u < 4; u++) begin
      in_valid_s[u]  = 1'b0;
      a_s[u]         = '0;
      b_s[u]         = '0;
      bin_s[u]       = 1'b0;
      out_ready_s[u] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) begin
      check("rst_out_valid", out_valid_s[u], 0);
      check("rst_in_ready", in_ready_s[u], 1);
      check("rst_diff", diff_s[u], 0);
      check("rst_bout", bout_s[u], 0);
      check("rst_ovf", ovf_s[u], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases on the K=4 instance.
    do_op(2, 8'h5A, 8'h3C, 1'b0, 0, 8'h1E, 1'b0, 1'b0);
    do_op(2, 8'h00, 8'h01, 1'b0, 0, 8'hFF, 1'b1, 1'b0);
    do_op(2, 8'h80, 8'h01, 1'b0, 0, 8'h7F, 1'b0, 1'b1);
    do_op(2, 8'h10, 8'h0F, 1'b1, 0, 8'h00, 1'b0, 1'b0);
    do_op(2, 8'h5A, 8'h3C, 1'b0, 5, 8'h1E, 1'b0, 1'b0);

    // Reset one cycle into BUSY: the operation is dropped immediately.
    out_ready_s[2] = 1'b1;
    a_s[2]         = 8'h5A;
    b_s[2]         = 8'h3C;
    bin_s[2]       = 1'b0;
    in_valid_s[2]  = 1'b1;
    @(posedge clk); #1;
    in_valid_s[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid_s[2], 0);
    check("midrst_diff", diff_s[2], 0);
    check("midrst_bout", bout_s[2], 0);
    check("midrst_ovf", ovf_s[2], 0);
    check("midrst_in_ready", in_ready_s[2], 1);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(2, 8'h5A, 8'h3C, 1'b0, 0, 8'h1E, 1'b0, 1'b0);

    // Random sweep over every K, occasionally with backpressure.
    for (int u = 0; u < 4; u++) begin
      for (int n = 0; n < 1000; n++) begin
        av   = 8'($urandom);
        bv   = 8'($urandom);
        bi   = 1'($urandom);
        hold = ($urandom_range(0, 7) == 0) ? 1 : 0;
        model(av, bv, bi, ed, eb, eo);
        do_op(u, av, bv, bi, hold, ed, eb, eo);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
